// File: rtl/batamateur_seq_controller_if.sv
// Control bus between the BatAmateur sequencer and its datapath.
// The master side is the sequencer: it reads IR/ALU flags/RAM ready and drives every strobe.
// The slave side is the datapath, which owns IR, ALU flags and RAM ready.
interface batamateur_seq_controller_if #(
    parameter int NREGS = 8,
    parameter int OP_W  = 5
);
    logic [15:0]      INSTR;
    logic [7:0]       ALU_REG;
    logic             MEM_READY;
    logic             PC_INC;
    logic             PC_RW;
    logic             PC_EN;
    logic             MAR_LOAD;
    logic             MAR_EN;
    logic             RAM_RW;
    logic             RAM_EN;
    logic             IR_LOAD;
    logic             IR_EN;
    logic [NREGS-1:0] REGS_INC;
    logic [NREGS-1:0] REGS_RW;
    logic [NREGS-1:0] REGS_EN;
    logic             ALU_EN;
    logic [OP_W-1:0]  ALU_OP;
    logic             HALTED;
    logic [2:0]       UOP;

    modport master (
        input  INSTR, ALU_REG, MEM_READY,
        output PC_INC, PC_RW, PC_EN, MAR_LOAD, MAR_EN, RAM_RW, RAM_EN,
               IR_LOAD, IR_EN, REGS_INC, REGS_RW, REGS_EN, ALU_EN, ALU_OP,
               HALTED, UOP
    );

    modport slave (
        output INSTR, ALU_REG, MEM_READY,
        input  PC_INC, PC_RW, PC_EN, MAR_LOAD, MAR_EN, RAM_RW, RAM_EN,
               IR_LOAD, IR_EN, REGS_INC, REGS_RW, REGS_EN, ALU_EN, ALU_OP,
               HALTED, UOP
    );
endinterface

// File: rtl/batamateur_seq_controller.sv
// BatAmateur instruction sequencer: decodes IR and drives PC/MAR/RAM/IR/register/ALU strobes.
// Optional single-step mode: define BATAMATEUR_STEP_EN to add STEP_i; each STEP_i pulse
// releases exactly one instruction from the pre-fetch hold.
//
// state   | code | meaning
// FETCH   | 0    | PC onto bus, load MAR
// DECODE  | 1    | RAM word into IR, PC increment (waits on MEM_READY)
// EX0     | 2    | first execute step / register group ops
// EX1     | 3    | second execute step (operand B, jump target, direct transfer)
// EX2     | 4    | ALU result write-back or indirect transfer
// IDLE    | 6    | pre-fetch hold, single-step build only
// HALT    | 7    | stopped until reset
module batamateur_seq_controller #(
    parameter int NREGS    = 8,
    parameter int OP_W     = 5,
    parameter int FLAG_BIT = 0
) (
    input  logic CLK_i,
    input  logic RST_i,
`ifdef BATAMATEUR_STEP_EN
    input  logic STEP_i,
`endif
    batamateur_seq_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EX0    = 3'd2,
        S_EX1    = 3'd3,
        S_EX2    = 3'd4,
        S_IDLE   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

`ifdef BATAMATEUR_STEP_EN
    localparam state_t S_DONE = S_IDLE;
`else
    localparam state_t S_DONE = S_FETCH;
`endif

    state_t state_q, state_d;

    logic             pc_inc, pc_rw, pc_en, mar_load, mar_en;
    logic             ram_rw, ram_en, ir_load, ir_en, alu_en, halted;
    logic [NREGS-1:0] regs_inc, regs_rw, regs_en;
    logic [OP_W-1:0]  alu_op;

    // One-hot register select; indices beyond the register file select nothing.
    function automatic logic [NREGS-1:0] reg_sel(input logic [2:0] idx);
        logic [NREGS-1:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) begin
            v[i] = (idx == 3'(i));
        end
        return v;
    endfunction

    logic [2:0] r1, r2;
    logic [4:0] grp_op;
    logic       is_reg_grp, is_nop, is_jmp_dir, is_jmp_ind, is_ldst;
    logic       is_mov, is_inc, is_halt;
    logic       flag, taken, is_store, is_ind_ls;
    logic [NREGS-1:0] acc_sel, dst_sel;
    logic       unused_alu_reg;

    assign r1         = bus.INSTR[5:3];
    assign r2         = bus.INSTR[2:0];
    assign grp_op     = bus.INSTR[11:7];
    assign is_reg_grp = (bus.INSTR[15:12] == 4'b0111);
    assign is_nop     = (bus.INSTR[15:12] == 4'b1111);
    assign is_jmp_dir = (bus.INSTR[15:14] == 2'b01) && !is_reg_grp;
    assign is_jmp_ind = (bus.INSTR[15:14] == 2'b11) && !is_nop;
    assign is_ldst    = !bus.INSTR[14];
    assign is_mov     = (grp_op == 5'b11111);
    assign is_inc     = (grp_op == 5'b11110);
    assign is_halt    = (grp_op == 5'b11101);
    assign flag       = bus.ALU_REG[FLAG_BIT];
    assign taken      = (bus.INSTR[13:12] == 2'b00) ||
                        (bus.INSTR[13:12] == 2'b01 && !flag) ||
                        (bus.INSTR[13:12] == 2'b10 && flag);
    assign is_store   = bus.INSTR[13];
    assign is_ind_ls  = bus.INSTR[15];
    assign acc_sel    = bus.INSTR[12] ? reg_sel(3'd1) : reg_sel(3'd0);
    assign dst_sel    = bus.INSTR[6]  ? reg_sel(3'd0) : reg_sel(3'd1);
    assign unused_alu_reg = ^bus.ALU_REG;

    // Next-state and strobe decode; reset forces every strobe to its idle value.
    always_comb begin
        state_d  = state_q;
        pc_inc   = 1'b0;
        pc_rw    = 1'b1;
        pc_en    = 1'b0;
        mar_load = 1'b0;
        mar_en   = 1'b1;
        ram_rw   = 1'b1;
        ram_en   = 1'b0;
        ir_load  = 1'b0;
        ir_en    = 1'b0;
        regs_inc = '0;
        regs_rw  = '1;
        regs_en  = '0;
        alu_en   = 1'b0;
        alu_op   = '0;
        halted   = 1'b0;
        if (!RST_i) begin
            case (state_q)
                S_FETCH: begin
                    pc_en    = 1'b1;
                    mar_load = 1'b1;
                    state_d  = S_DECODE;
                end
                S_DECODE: begin
                    ram_en  = 1'b1;
                    ir_load = 1'b1;
                    pc_rw   = 1'b0;
                    if (bus.MEM_READY) begin
                        pc_inc  = 1'b1;
                        state_d = S_EX0;
                    end
                end
                S_EX0: begin
                    if (is_reg_grp) begin
                        if (is_mov) begin
                            regs_en = reg_sel(r1) | reg_sel(r2);
                            regs_rw = ~reg_sel(r1);
                            state_d = S_DONE;
                        end else if (is_inc) begin
                            regs_inc = reg_sel(r1);
                            regs_rw  = ~reg_sel(r1);
                            state_d  = S_DONE;
                        end else if (is_halt) begin
                            state_d = S_HALT;
                        end else begin
                            if (r1 != 3'd0) begin
                                regs_en = reg_sel(3'd0) | reg_sel(r1);
                                regs_rw = ~reg_sel(3'd0);
                            end
                            state_d = S_EX1;
                        end
                    end else if (is_nop) begin
                        state_d = S_DONE;
                    end else if (is_jmp_dir) begin
                        if (taken) begin
                            ir_en = 1'b1;
                            pc_en = 1'b1;
                            pc_rw = 1'b0;
                        end else begin
                            pc_inc = 1'b1;
                        end
                        state_d = S_DONE;
                    end else begin
                        // indirect jump and load/store both start by moving the IR address into MAR
                        ir_en    = 1'b1;
                        mar_load = 1'b1;
                        state_d  = S_EX1;
                    end
                end
                S_EX1: begin
                    if (is_reg_grp) begin
                        if (r2 != 3'd1) begin
                            regs_en = reg_sel(3'd1) | reg_sel(r2);
                            regs_rw = ~reg_sel(3'd1);
                        end
                        state_d = S_EX2;
                    end else if (is_jmp_ind) begin
                        if (taken) begin
                            ram_en  = 1'b1;
                            pc_en   = 1'b1;
                            pc_rw   = 1'b0;
                            state_d = bus.MEM_READY ? S_DONE : S_EX1;
                        end else begin
                            pc_inc  = 1'b1;
                            state_d = S_DONE;
                        end
                    end else if (is_ldst && is_ind_ls) begin
                        ram_en   = 1'b1;
                        mar_load = 1'b1;
                        state_d  = bus.MEM_READY ? S_EX2 : S_EX1;
                    end else if (is_ldst) begin
                        ram_en  = 1'b1;
                        ram_rw  = !is_store;
                        regs_en = acc_sel;
                        if (!is_store) regs_rw = ~acc_sel;
                        state_d = bus.MEM_READY ? S_DONE : S_EX1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_EX2: begin
                    if (is_reg_grp) begin
                        alu_en  = 1'b1;
                        alu_op  = bus.INSTR[6+OP_W:7];
                        regs_en = dst_sel;
                        regs_rw = ~dst_sel;
                        state_d = S_DONE;
                    end else if (is_ldst && is_ind_ls) begin
                        ram_en  = 1'b1;
                        ram_rw  = !is_store;
                        regs_en = acc_sel;
                        if (!is_store) regs_rw = ~acc_sel;
                        state_d = bus.MEM_READY ? S_DONE : S_EX2;
                    end else begin
                        state_d = S_DONE;
                    end
                end
`ifdef BATAMATEUR_STEP_EN
                S_IDLE: begin
                    if (STEP_i) state_d = S_FETCH;
                end
`endif
                S_HALT: begin
                    halted  = 1'b1;
                    state_d = S_HALT;
                end
                default: begin
                    mar_en  = 1'b0;
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // State register with synchronous reset into the pre-fetch point.
    always_ff @(posedge CLK_i) begin
        if (RST_i) state_q <= S_DONE;
        else       state_q <= state_d;
    end

    assign bus.PC_INC   = pc_inc;
    assign bus.PC_RW    = pc_rw;
    assign bus.PC_EN    = pc_en;
    assign bus.MAR_LOAD = mar_load;
    assign bus.MAR_EN   = mar_en;
    assign bus.RAM_RW   = ram_rw;
    assign bus.RAM_EN   = ram_en;
    assign bus.IR_LOAD  = ir_load;
    assign bus.IR_EN    = ir_en;
    assign bus.REGS_INC = regs_inc;
    assign bus.REGS_RW  = regs_rw;
    assign bus.REGS_EN  = regs_en;
    assign bus.ALU_EN   = alu_en;
    assign bus.ALU_OP   = alu_op;
    assign bus.HALTED   = halted;
    assign bus.UOP      = state_q;

endmodule

// File: tb/tb_batamateur_seq_controller.sv
// Directed bench for batamateur_seq_controller (default build, continuous fetch).
// A second instance with four registers shares all inputs to observe dropped strobes.
module tb_batamateur_seq_controller;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    batamateur_seq_controller_if #(.NREGS(8), .OP_W(5)) bus ();
    batamateur_seq_controller_if #(.NREGS(4), .OP_W(5)) bus4 ();

    batamateur_seq_controller #(.NREGS(8), .OP_W(5), .FLAG_BIT(0)) dut (
        .CLK_i (CLK),
        .RST_i (RST),
`ifdef BATAMATEUR_STEP_EN
        .STEP_i(1'b1),
`endif
        .bus   (bus)
    );

    batamateur_seq_controller #(.NREGS(4), .OP_W(5), .FLAG_BIT(0)) dut4 (
        .CLK_i (CLK),
        .RST_i (RST),
`ifdef BATAMATEUR_STEP_EN
        .STEP_i(1'b1),
`endif
        .bus   (bus4)
    );

    assign bus4.INSTR     = bus.INSTR;
    assign bus4.ALU_REG   = bus.ALU_REG;
    assign bus4.MEM_READY = bus.MEM_READY;

    typedef struct packed {
        logic [2:0] uop;
        logic       pc_inc, pc_rw, pc_en, mar_load, mar_en;
        logic       ram_rw, ram_en, ir_load, ir_en;
        logic [7:0] regs_inc, regs_rw, regs_en;
        logic       alu_en;
        logic [4:0] alu_op;
        logic       halted;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  exp;
    } sb_t;

    sb_t sb_q[$];
    int  tests = 0;
    int  fails = 0;

    function automatic obs_t dflt(input logic [2:0] u);
        obs_t o;
        o = '0;
        o.uop = u; o.pc_rw = 1'b1; o.mar_en = 1'b1; o.ram_rw = 1'b1; o.regs_rw = 8'hFF;
        return o;
    endfunction

    function automatic obs_t fe();
        obs_t o;
        o = dflt(3'd0); o.pc_en = 1'b1; o.mar_load = 1'b1;
        return o;
    endfunction

    function automatic obs_t de();
        obs_t o;
        o = dflt(3'd1); o.ram_en = 1'b1; o.ir_load = 1'b1; o.pc_inc = 1'b1; o.pc_rw = 1'b0;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.uop = bus.UOP; o.pc_inc = bus.PC_INC; o.pc_rw = bus.PC_RW; o.pc_en = bus.PC_EN;
        o.mar_load = bus.MAR_LOAD; o.mar_en = bus.MAR_EN; o.ram_rw = bus.RAM_RW;
        o.ram_en = bus.RAM_EN; o.ir_load = bus.IR_LOAD; o.ir_en = bus.IR_EN;
        o.regs_inc = bus.REGS_INC; o.regs_rw = bus.REGS_RW; o.regs_en = bus.REGS_EN;
        o.alu_en = bus.ALU_EN; o.alu_op = bus.ALU_OP; o.halted = bus.HALTED;
        return o;
    endfunction

    // Push the expectation for the current cycle, observe the DUT, then advance one clock.
    task automatic step(input string tag, input obs_t e);
        sb_t  s;
        obs_t a;
        s.tag = tag; s.exp = e;
        sb_q.push_back(s);
        #1;
        a = sample();
        s = sb_q.pop_front();
        tests++;
        assert (a === s.exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", s.tag, a, s.exp);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic fd(input string tag);
        step({tag, "_fetch"}, fe());
        step({tag, "_decode"}, de());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        obs_t e;
        RST = 1'b1;
        bus.INSTR = 16'hF000; bus.ALU_REG = 8'h00; bus.MEM_READY = 1'b1;
        @(posedge CLK); #1;
        step("rst0", dflt(3'd0));
        step("rst1", dflt(3'd0));
        RST = 1'b0;

        fd("nop");
        step("nop_ex0", dflt(3'd2));

        bus.INSTR = 16'h7FCA;
        fd("mov");
        e = dflt(3'd2); e.regs_en = 8'h06; e.regs_rw = 8'hFD;
        step("mov_ex0", e);

        bus.INSTR = 16'h7FEA;
        fd("movdrop");
        #1;
        tests++;
        assert (bus4.REGS_EN === 4'h4 && bus4.REGS_RW === 4'hF) else begin
            fails++;
            $error("FAIL movdrop_n4: observed en=%h rw=%h expected en=4 rw=f", bus4.REGS_EN, bus4.REGS_RW);
        end
        e = dflt(3'd2); e.regs_en = 8'h24; e.regs_rw = 8'hDF;
        step("movdrop_ex0", e);

        bus.INSTR = 16'h7F18;
        fd("inc");
        e = dflt(3'd2); e.regs_inc = 8'h08; e.regs_rw = 8'hF7;
        step("inc_ex0", e);

        bus.INSTR = 16'h700A;
        fd("alu0");
        e = dflt(3'd2); e.regs_en = 8'h03; e.regs_rw = 8'hFE;
        step("alu0_ex0", e);
        e = dflt(3'd3); e.regs_en = 8'h06; e.regs_rw = 8'hFD;
        step("alu0_ex1", e);
        e = dflt(3'd4); e.alu_en = 1'b1; e.regs_en = 8'h02; e.regs_rw = 8'hFD;
        step("alu0_ex2", e);

        bus.INSTR = 16'h71C1;
        fd("alu3");
        step("alu3_ex0", dflt(3'd2));
        step("alu3_ex1", dflt(3'd3));
        e = dflt(3'd4); e.alu_en = 1'b1; e.alu_op = 5'd3; e.regs_en = 8'h01; e.regs_rw = 8'hFE;
        step("alu3_ex2", e);

        bus.INSTR = 16'h5000; bus.ALU_REG = 8'h00;
        fd("jz_t");
        e = dflt(3'd2); e.ir_en = 1'b1; e.pc_en = 1'b1; e.pc_rw = 1'b0;
        step("jz_t_ex0", e);

        bus.ALU_REG = 8'h01;
        fd("jz_n");
        e = dflt(3'd2); e.pc_inc = 1'b1;
        step("jz_n_ex0", e);

        bus.INSTR = 16'h4000;
        fd("jmp");
        e = dflt(3'd2); e.ir_en = 1'b1; e.pc_en = 1'b1; e.pc_rw = 1'b0;
        step("jmp_ex0", e);

        bus.INSTR = 16'h6000; bus.ALU_REG = 8'h00;
        fd("jc_n");
        e = dflt(3'd2); e.pc_inc = 1'b1;
        step("jc_n_ex0", e);

        bus.INSTR = 16'hD000;
        fd("ijz");
        e = dflt(3'd2); e.ir_en = 1'b1; e.mar_load = 1'b1;
        step("ijz_ex0", e);
        bus.MEM_READY = 1'b0;
        e = dflt(3'd3); e.ram_en = 1'b1; e.pc_en = 1'b1; e.pc_rw = 1'b0;
        step("ijz_ex1_wait", e);
        bus.MEM_READY = 1'b1;
        step("ijz_ex1", e);

        bus.INSTR = 16'hE000;
        fd("ijc_n");
        e = dflt(3'd2); e.ir_en = 1'b1; e.mar_load = 1'b1;
        step("ijc_n_ex0", e);
        e = dflt(3'd3); e.pc_inc = 1'b1;
        step("ijc_n_ex1", e);

        bus.INSTR = 16'h2000;
        fd("sta");
        e = dflt(3'd2); e.ir_en = 1'b1; e.mar_load = 1'b1;
        step("sta_ex0", e);
        bus.MEM_READY = 1'b0;
        e = dflt(3'd3); e.ram_en = 1'b1; e.ram_rw = 1'b0; e.regs_en = 8'h01;
        for (int i = 0; i < 3; i++) step("sta_ex1_wait", e);
        bus.MEM_READY = 1'b1;
        step("sta_ex1", e);

        bus.INSTR = 16'h9000;
        fd("ldbi");
        e = dflt(3'd2); e.ir_en = 1'b1; e.mar_load = 1'b1;
        step("ldbi_ex0", e);
        e = dflt(3'd3); e.ram_en = 1'b1; e.mar_load = 1'b1;
        step("ldbi_ex1", e);
        e = dflt(3'd4); e.ram_en = 1'b1; e.regs_en = 8'h02; e.regs_rw = 8'hFD;
        step("ldbi_ex2", e);

        bus.INSTR = 16'hF000;
        step("dwait_fetch", fe());
        bus.MEM_READY = 1'b0;
        e = de(); e.pc_inc = 1'b0;
        step("dwait_decode", e);
        bus.MEM_READY = 1'b1;
        step("dwait_decode_go", de());
        step("dwait_ex0", dflt(3'd2));

        bus.INSTR = 16'h700A;
        fd("abort");
        e = dflt(3'd2); e.regs_en = 8'h03; e.regs_rw = 8'hFE;
        step("abort_ex0", e);
        RST = 1'b1;
        step("abort_rst", dflt(3'd3));
        RST = 1'b0;
        step("abort_fetch", fe());
        step("abort_decode", de());

        bus.INSTR = 16'h7E80;
        step("halt_ex0", dflt(3'd2));
        e = dflt(3'd7); e.halted = 1'b1;
        for (int i = 0; i < 3; i++) step("halt_hold", e);
        bus.INSTR = 16'hF000; bus.MEM_READY = 1'b0;
        for (int i = 0; i < 2; i++) step("halt_hold2", e);
        bus.MEM_READY = 1'b1;
        RST = 1'b1;
        step("halt_rst", dflt(3'd7));
        RST = 1'b0;
        step("halt_exit_fetch", fe());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/batamateur_seq_controller.md
Name: batamateur_seq_controller

Overview:
Parametrised successor to the BatAmateur microcoded controller. It decodes the 16-bit instruction held in IR and sequences PC, MAR, RAM, IR, register file and ALU control strobes through an explicit state machine. It adds three things: a configurable register count, a RAM wait handshake (MEM_READY), and a HALT instruction with a HALTED status output. It sits between IR/ALU flags and every datapath enable.

Parameters:
NREGS, 8, number of general registers (2..8); index 0 = A, 1 = B, NREGS-1 = OUT.
OP_W, 5, ALU opcode width; ALU_OP is driven from INSTR[6+OP_W:7].
FLAG_BIT, 0, bit of ALU_REG tested by conditional jumps.

Ports:
CLK  in  1  system clock; all state changes on the rising edge.
RST  in  1  synchronous, active-high reset.
INSTR  in  16  current IR contents.
ALU_REG  in  8  ALU flag register.
MEM_READY  in  1  RAM access completes this cycle when high.
PC_INC, PC_RW, PC_EN  out  1 each  program counter controls (RW: 1 = read out, 0 = load).
MAR_LOAD, MAR_EN  out  1 each  memory address register controls.
RAM_RW, RAM_EN  out  1 each  RAM controls (RW: 1 = read, 0 = write).
IR_LOAD, IR_EN  out  1 each  instruction register controls.
REGS_INC, REGS_RW, REGS_EN  out  NREGS each  per-register controls.
ALU_EN  out  1  ALU result drives the bus.
ALU_OP  out  OP_W  ALU operation.
HALTED  out  1  high while in the HALT state.
UOP  out  3  current state code, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, EX0=2, EX1=3, EX2=4, HALT=7. State register is updated on the rising edge of CLK. All outputs are combinational from the state and INSTR.
- Default outputs (every state unless overridden): PC_RW=1, MAR_EN=1, RAM_RW=1, REGS_RW=all 1. Every other output is 0.
- Reset: while RST=1, state is forced to FETCH and outputs take their defaults. PC_EN and MAR_LOAD are masked to 0 while RST=1. RST mid-instruction aborts the instruction; the first cycle after RST falls is FETCH.
- FETCH: PC_EN=1, MAR_LOAD=1. Next state is DECODE.
- DECODE: RAM_EN=1, IR_LOAD=1, PC_INC=1, PC_RW=0. If MEM_READY=0, stay in DECODE with all outputs held and PC_INC suppressed. Otherwise go to EX0.
- Fields: r1=INSTR[5:3], r2=INSTR[2:0]. Any strobe to an index >= NREGS is dropped; the instruction still completes.
- Register group (INSTR[15:12]=0111), handled in EX0:
  - MOV (op 11111): EN[r1]=1, RW[r1]=0, EN[r2]=1. Next state FETCH.
  - INC (op 11110): INC[r1]=1, RW[r1]=0. Next state FETCH.
  - HALT (op 11101): next state HALT.
  - Any other op is an ALU op:
    - EX0: if r1 != 0, move r1 into A (EN[0]=1, RW[0]=0, EN[r1]=1).
    - EX1: if r2 != 1, move r2 into B (EN[1]=1, RW[1]=0, EN[r2]=1).
    - EX2: ALU_EN=1, ALU_OP=INSTR[6+OP_W:7]; destination is A if INSTR[6]=1, else B (EN=1, RW=0). Next state FETCH.
- NOP (INSTR[15:12]=1111): EX0 goes straight to FETCH.
- Jump taken condition: cond=INSTR[13:12]. Taken when cond=00, or cond=01 and flag=0, or cond=10 and flag=1. Not taken otherwise.
- Direct jump (INSTR[15:14]=01), EX0:
  - Taken: IR_EN=1, PC_EN=1, PC_RW=0.
  - Not taken: PC_INC=1.
  - Next state FETCH.
- Indirect jump (INSTR[15:14]=11, not NOP):
  - EX0: IR_EN=1, MAR_LOAD=1.
  - EX1, taken: RAM_EN=1, PC_EN=1, PC_RW=0. Not taken: PC_INC=1. Next state FETCH.
- Load/store (INSTR[14]=0): the accumulator is A if INSTR[12]=0, else B.
  - EX0: IR_EN=1, MAR_LOAD=1.
  - Direct (INSTR[15]=0): transfer in EX1.
  - Indirect (INSTR[15]=1): EX1 does RAM_EN=1, MAR_LOAD=1 (pointer to MAR); transfer in EX2.
  - Store transfer: acc EN=1 with RW left at 1, RAM_EN=1, RAM_RW=0.
  - Load transfer: acc EN=1, RW=0, RAM_EN=1.
  - Then FETCH.
- Wait rule: any state asserting RAM_EN with MEM_READY=0 holds its state and outputs. The wait is unbounded.
- HALT: HALTED=1, all outputs at default, no exit except RST.
- An undefined state code recovers to FETCH next cycle with MAR_EN=0.

Optional Feature:
BATAMATEUR_STEP_EN: adds input STEP (1 bit).
- Defined: FETCH is entered only on a cycle where STEP=1; otherwise the controller idles in the pre-fetch hold with default outputs. Exactly one instruction runs per STEP pulse.
- Undefined: STEP is absent and fetch is continuous.

Test Plan:
- RST=1 for 2 cycles, then 0 -> outputs at defaults during reset; UOP=0 and PC_EN=1, MAR_LOAD=1 in the first cycle after RST falls.
- INSTR=0x7FCA (MOV r1=1, r2=2) -> in EX0, REGS_EN=0x06, REGS_RW=0xFD; next UOP=0.
- INSTR=0x700A (ALU op 0, r1=1, r2=2, dest B) -> EX0 REGS_EN=0x03, EX1 REGS_EN=0x06, EX2 ALU_EN=1, REGS_EN=0x02, REGS_RW=0xFD.
- INSTR=0x5000 with ALU_REG=0x00 -> EX0 IR_EN=1, PC_EN=1, PC_RW=0. With ALU_REG=0x01 -> PC_INC=1 only.
- INSTR=0x2000 (store A) with MEM_READY low for 3 cycles in EX1 -> UOP stays 3 with RAM_EN=1, RAM_RW=0, REGS_EN=0x01 held for 4 cycles, then FETCH.
- INSTR=0x7E80 (HALT) -> HALTED=1 and UOP=7 indefinitely; RST=1 returns the controller to FETCH.
